// File: rtl/step_ena_scheduler.sv
// Per-time-step sequencer: periodic step tick, then in-order enable windows
// to NUM_STAGES solver stages, each waiting on its done, with error flags.
//
// state  | meaning
// S_IDLE | no step in progress, waiting for step_tick
// S_ENA  | stage_ena[r_k] high, window counter running
// S_WAIT | window closed, waiting for stage r_k done or TIMEOUT
module step_ena_scheduler #(
  parameter int NUM_STAGES = 4,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [CNT_W-1:0]            period,
  input  logic [NUM_STAGES*LEN_W-1:0] ena_len,
  input  logic [NUM_STAGES-1:0]       stage_done,
  input  logic                        err_clr,
  output logic                        step_tick,
  output logic [NUM_STAGES-1:0]       stage_ena,
  output logic                        busy,
  output logic [15:0]                 step_cnt,
  output logic                        overrun,
  output logic                        timeout_err
);

  localparam int K_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [K_W-1:0] LAST = K_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENA, S_WAIT} state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_pcnt;
  logic [CNT_W-1:0]            r_period_l;
  logic [K_W-1:0]              r_k;
  logic [NUM_STAGES*LEN_W-1:0] r_len_l;
  logic [LEN_W-1:0]            r_ecnt;
  logic [TO_W-1:0]             r_wcnt;
  logic                        r_done_seen;

  logic [CNT_W-1:0] w_period_clamp;
  logic [K_W-1:0]   w_k_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_len0;
  logic             w_done_k;
  logic             w_wait_exit;
  logic             w_to_set;
  logic             w_ovr_set;

  // Window counter load: a zero length still yields a one-cycle window.
  function automatic logic [LEN_W-1:0] win_load(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_comb begin
    w_period_clamp = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    w_k_nxt        = (r_k == LAST) ? '0 : r_k + 1'b1;
    w_len_nxt      = r_len_l[int'(w_k_nxt)*LEN_W +: LEN_W];
    w_len0         = ena_len[LEN_W-1:0];
    w_done_k       = r_done_seen | stage_done[r_k];
    w_wait_exit    = (r_state == S_WAIT) && (w_done_k || (r_wcnt == '0));
    w_to_set       = (r_state == S_WAIT) && !w_done_k && (r_wcnt == '0);
    w_ovr_set      = step_tick && busy;
  end

  // Step period counter; the period is latched only when a new step starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_period_l <= '0;
      step_tick  <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (!run) begin
        r_pcnt <= '0;
      end else if (r_pcnt == '0) begin
        step_tick  <= 1'b1;
        r_period_l <= w_period_clamp;
        r_pcnt     <= CNT_W'(1);
      end else if (r_pcnt == r_period_l - CNT_W'(1)) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_len_l     <= '0;
      r_ecnt      <= '0;
      r_wcnt      <= '0;
      r_done_seen <= 1'b0;
      stage_ena   <= '0;
      busy        <= 1'b0;
      step_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (step_tick) begin
            r_len_l     <= ena_len;
            r_k         <= '0;
            r_ecnt      <= win_load(w_len0);
            r_done_seen <= 1'b0;
            stage_ena   <= NUM_STAGES'(1);
            busy        <= 1'b1;
            r_state     <= S_ENA;
          end
        end
        S_ENA: begin
          // Capture done during the window so a short pulse is never lost.
          if (stage_done[r_k]) r_done_seen <= 1'b1;
          if (r_ecnt == '0) begin
            stage_ena <= '0;
            r_wcnt    <= TO_W'(TIMEOUT - 1);
            r_state   <= S_WAIT;
          end else begin
            r_ecnt <= r_ecnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (w_wait_exit) begin
            r_done_seen <= 1'b0;
            if (r_k == LAST) begin
              busy     <= 1'b0;
              step_cnt <= step_cnt + 16'd1;
              r_state  <= S_IDLE;
            end else begin
              r_k       <= w_k_nxt;
              r_ecnt    <= win_load(w_len_nxt);
              stage_ena <= NUM_STAGES'(1) << w_k_nxt;
              r_state   <= S_ENA;
            end
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        default: begin
          stage_ena <= '0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set on the same edge as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (w_ovr_set)    overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (w_to_set)     timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_ena_scheduler.sv
// Self-checking bench for step_ena_scheduler: a per-step timeline model
// predicts every output cycle by cycle from tick times, lengths and done modes.
module tb_step_ena_scheduler;
  localparam int NS   = 4;
  localparam int LW   = 8;
  localparam int TO   = 8;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          err_clr = 1'b0;
  logic [15:0]   period = '0;
  logic [NS*LW-1:0] ena_len = '0;
  logic [NS-1:0] stage_done = '0;
  logic          step_tick;
  logic [NS-1:0] stage_ena;
  logic          busy;
  logic [15:0]   step_cnt;
  logic          overrun;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model outputs per cycle
  bit       m_tick[MAXC];
  bit [3:0] m_ena[MAXC];
  bit       m_busy[MAXC];
  int       m_cnt[MAXC];
  bit       m_ovr_set[MAXC];
  bit       m_to_set[MAXC];
  bit       m_ovr[MAXC];
  bit       m_to[MAXC];
  // Stimulus per cycle
  bit [3:0] s_done[MAXC];
  bit       s_clr[MAXC];
  int       s_per[MAXC];
  // Done mode: 0 tied high, 1 never (timeout), 2 pulse in window, 3 pulse in wait
  int c_len[NS];
  int c_mode[NS];
  int c_off[NS];
  int run_stop;

  step_ena_scheduler #(.NUM_STAGES(NS), .LEN_W(LW), .CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .period(period), .ena_len(ena_len),
    .stage_done(stage_done), .err_clr(err_clr), .step_tick(step_tick),
    .stage_ena(stage_ena), .busy(busy), .step_cnt(step_cnt),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic set_defaults(input int per, input int l0, input int l1, input int l2, input int l3);
    for (int c = 0; c < MAXC; c++) begin
      s_per[c] = per;
      s_clr[c] = 1'b0;
    end
    c_len[0] = l0; c_len[1] = l1; c_len[2] = l2; c_len[3] = l3;
    for (int k = 0; k < NS; k++) begin
      c_mode[k] = 0;
      c_off[k]  = 0;
    end
    run_stop = MAXC;
  endtask

  // Tick at 1 + sum of clamped periods; each accepted step lays out windows
  // back to back: window of max(len,1), then a wait set by the done mode.
  task automatic build_model(input int n);
    int t, s, w, wl, len, fin, p, o, busy_end;
    for (int c = 0; c < MAXC; c++) begin
      m_tick[c] = 0; m_ena[c] = '0; m_busy[c] = 0; m_cnt[c] = 0;
      m_ovr_set[c] = 0; m_to_set[c] = 0; m_ovr[c] = 0; m_to[c] = 0;
      for (int k = 0; k < NS; k++) s_done[c][k] = (c_mode[k] == 0);
    end
    busy_end = 0;
    t = 1;
    while (t < n && t <= run_stop) begin
      m_tick[t] = 1;
      if (t <= busy_end) begin
        m_ovr_set[t] = 1;
      end else begin
        s = t + 1;
        for (int k = 0; k < NS; k++) begin
          len = (c_len[k] == 0) ? 1 : c_len[k];
          for (int i = 0; i < len; i++) if (s + i < n) m_ena[s+i] = 4'(1 << k);
          w = s + len;
          case (c_mode[k])
            0: wl = 1;
            1: begin
              wl = TO;
              if (w + TO - 1 < n) m_to_set[w+TO-1] = 1;
            end
            2: begin
              o = c_off[k] % len;
              if (s + o < n) s_done[s+o][k] = 1'b1;
              wl = 1;
            end
            default: begin
              wl = (c_off[k] % TO) + 1;
              if (w + wl - 1 < n) s_done[w+wl-1][k] = 1'b1;
            end
          endcase
          s = w + wl;
        end
        fin = s - 1;
        for (int c = t + 1; c <= fin && c < n; c++) m_busy[c] = 1;
        for (int c = fin + 1; c < n; c++) m_cnt[c]++;
        busy_end = fin;
      end
      p = (s_per[t-1] < 2) ? 2 : s_per[t-1];
      t += p;
    end
    for (int c = 0; c + 1 < n; c++) begin
      m_ovr[c+1] = m_ovr_set[c] | (m_ovr[c] & !s_clr[c]);
      m_to[c+1]  = m_to_set[c]  | (m_to[c]  & !s_clr[c]);
    end
  endtask

  function automatic logic [23:0] exp_vec(input int c);
    return {m_tick[c], m_ena[c], m_busy[c], 16'(m_cnt[c]), m_ovr[c], m_to[c]};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {step_tick, stage_ena, busy, step_cnt, overrun, timeout_err};
  endfunction

  // Resets the DUT and returns just after the edge that starts cycle 0.
  task automatic scen_begin();
    rst = 1'b1; run = 1'b0; err_clr = 1'b0; stage_done = '0;
    period  = 16'(s_per[0]);
    ena_len = {8'(c_len[3]), 8'(c_len[2]), 8'(c_len[1]), 8'(c_len[0])};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input int c);
    run        = (c < run_stop);
    period     = 16'(s_per[c]);
    stage_done = s_done[c];
    err_clr    = s_clr[c];
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; period = 16'd5; stage_done = '1; ena_len = '1;
    repeat (3) @(negedge clk);
    n_cmp++; if (step_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", step_tick); end
    n_cmp++; if (stage_ena !== 4'b0) begin n_err++; $display("FAIL reset_ena got=%b exp=0000", stage_ena); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (step_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", step_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_to got=%b exp=0", timeout_err); end
  endtask

  task automatic test_nominal();
    set_defaults(20, 1, 2, 3, 4);
    build_model(90);
    scen_begin();
    for (int c = 0; c < 90; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL nominal cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overrun();
    set_defaults(12, 1, 2, 3, 4);
    s_clr[37] = 1'b1;
    s_clr[50] = 1'b1;
    build_model(80);
    scen_begin();
    for (int c = 0; c < 80; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL overrun cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_done();
    set_defaults(30, 1, 2, 3, 4);
    c_mode[1] = 2;
    c_off[1]  = 1;
    build_model(70);
    scen_begin();
    for (int c = 0; c < 70; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL early_done cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    set_defaults(60, 1, 2, 3, 4);
    c_mode[2] = 1;
    s_clr[40] = 1'b1;
    build_model(130);
    scen_begin();
    for (int c = 0; c < 130; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_len();
    set_defaults(1, 0, 0, 0, 0);
    build_model(40);
    scen_begin();
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL zero_len cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_period_run();
    set_defaults(20, 1, 2, 3, 4);
    for (int c = 30; c < MAXC; c++) s_per[c] = 7;
    run_stop = 85;
    build_model(140);
    scen_begin();
    for (int c = 0; c < 140; c++) begin
      drive_cycle(c);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec(c)) begin
        n_err++; $display("FAIL period_run cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec(c));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int chg, per_a, per_b;
    for (int it = 0; it < 6; it++) begin
      per_a = $urandom_range(0, 40);
      per_b = $urandom_range(0, 40);
      set_defaults(per_a, $urandom_range(0, 6), $urandom_range(0, 6),
                   $urandom_range(0, 6), $urandom_range(0, 6));
      chg = $urandom_range(10, 200);
      for (int c = chg; c < MAXC; c++) s_per[c] = per_b;
      for (int c = 0; c < MAXC; c++) s_clr[c] = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < NS; k++) begin
        c_mode[k] = $urandom_range(0, 3);
        c_off[k]  = $urandom_range(0, 15);
      end
      run_stop = $urandom_range(150, 300);
      build_model(300);
      scen_begin();
      for (int c = 0; c < 300; c++) begin
        drive_cycle(c);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec(c)) begin
          n_err++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, c, obs_vec(), exp_vec(c));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    set_defaults(20, 1, 2, 3, 4);
    scen_begin();
    run = 1'b1;
    stage_done = '1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (step_cnt >= 16'd1 && stage_ena == 4'b0100) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL async_reach got=ena %b cnt %0d exp=ena 0100 after a step", stage_ena, step_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (stage_ena !== 4'b0) begin n_err++; $display("FAIL async_ena got=%b exp=0000", stage_ena); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got=%b exp=0", busy); end
    n_cmp++; if (step_cnt !== 16'd0) begin n_err++; $display("FAIL async_cnt got=%0d exp=0", step_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (step_tick !== 1'b0) begin n_err++; $display("FAIL async_pre_tick got=%b exp=0", step_tick); end
    @(negedge clk);
    n_cmp++;
    if ({step_tick, stage_ena, busy} !== {1'b1, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL async_tick got=%b/%b/%b exp=1/0000/0", step_tick, stage_ena, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({step_tick, stage_ena, busy} !== {1'b0, 4'b0001, 1'b1}) begin
      n_err++; $display("FAIL async_restart got=%b/%b/%b exp=0/0001/1", step_tick, stage_ena, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_early_done();
    test_timeout();
    test_zero_len();
    test_period_run();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_ena_scheduler.md
Name: step_ena_scheduler

Overview:
- Per-simulation-time-step sequencer for the real-time solver pipeline.
- Generates the periodic step tick, then issues enable windows to NUM_STAGES solver stages strictly in order (stage 0 first).
- Waits for each stage's done before enabling the next.
- Flags step overruns and stage timeouts so host logic can detect loss of real-time.

Parameters:
- NUM_STAGES, 4, number of sequenced stages (2..8).
- LEN_W, 8, width of each per-stage enable-window length field.
- CNT_W, 16, width of period counter and period input.
- TIMEOUT, 1000, maximum WAIT cycles per stage before forced advance.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = generate step ticks, 0 = stop new steps.
- period  in  CNT_W  clock cycles per time step; sampled at each step start.
- ena_len  in  NUM_STAGES*LEN_W  packed window lengths; stage k at bits [k*LEN_W +: LEN_W].
- stage_done  in  NUM_STAGES  per-stage completion (pulse or level).
- err_clr  in  1  clears overrun and timeout_err.
- step_tick  out  1  one-cycle pulse at each step start.
- stage_ena  out  NUM_STAGES  one-hot-or-zero enable window.
- busy  out  1  high while a step sequence is in progress.
- step_cnt  out  16  completed steps, wraps 0xFFFF->0.
- overrun  out  1  sticky: tick arrived while busy.
- timeout_err  out  1  sticky: a stage hit TIMEOUT.

Behaviour:
- Reset (async, immediate): all outputs 0; pcnt=0; FSM=IDLE; latched period/lengths=0.
- Period counter:
  - run=0: pcnt held 0, no ticks.
  - run=1 and pcnt==0: step_tick<=1 and period_l<=max(period,2); the first tick appears the cycle after run is first sampled high.
  - pcnt increments each cycle and wraps to 0 when pcnt==period_l-1.
  - A period change takes effect only at the next pcnt==0.
- FSM states: IDLE, ENA, WAIT.
  - IDLE & step_tick: latch all ena_len; k<=0; stage_ena[0]<=1; enter ENA.
  - ENA: stage_ena[k] stays high for exactly max(len_k,1) cycles, then falls; enter WAIT.
  - WAIT: exits on the edge where done_seen_k or stage_done[k] is 1.
    - If k<NUM_STAGES-1: k++, stage_ena[k] rises on the same edge, enter ENA. This gives exactly 1 low cycle between windows when done is already present.
    - If k==NUM_STAGES-1: enter IDLE and step_cnt++.
  - done_seen_k: sticky capture of stage_done[k], armed from the first ENA cycle of stage k and cleared on advance. A done pulse during the window is never lost.
  - WAIT timeout: if the WAIT cycle count reaches TIMEOUT with no done, set timeout_err and advance as if done.
- busy = (state != IDLE), registered; high from the first ENA cycle through the last WAIT cycle.
- Overrun: step_tick while busy sets overrun; that tick is dropped (not queued) and the sequence continues undisturbed.
- err_clr clears overrun and timeout_err. A simultaneous set and clear leaves the flag set.
- run falling mid-sequence: the current step completes normally; no further ticks.
- At most one bit of stage_ena is high at any time. stage_ena is never high in IDLE.
- Reset mid-sequence: all enables drop immediately; the next step restarts at stage 0.

Test Plan:
- Nominal: NUM_STAGES=4, period=20, ena_len={4,3,2,1} (stage3..0), stage_done tied 1, run=1 -> with tick at T:
  - ena0 at T+1; ena1 at T+3..4; ena2 at T+6..8; ena3 at T+10..13.
  - busy T+1..T+14; step_cnt increments at the T+15 edge.
  - Ticks every 20 cycles; overrun stays 0.
- Overrun: same config with period=12 -> second tick lands while busy: overrun=1, no restart of stage 0, step_cnt increments once per two ticks. err_clr pulse -> overrun=0.
- Early done pulse: stage_done[1] pulses 1 cycle during ena1's window, otherwise 0 -> captured; ena2 rises 2 cycles after ena1 falls (1 WAIT cycle gap), no hang.
- Timeout: TIMEOUT=8, stage_done[2]=0 -> WAIT lasts 8 cycles, timeout_err=1, ena3 still issued, step completes.
- Zero length and period clamp: ena_len all 0, period=1 -> each window lasts 1 cycle, ticks every 2 cycles, overrun set.
- Async reset asserted during ena2 -> stage_ena, busy and step_cnt go 0 immediately. After release with run=1, the first tick comes one cycle after run is sampled high and sequencing restarts at stage 0.
